random_word_scheduler: RTL and testbench
========================================

// Module: random_word_scheduler
// PURPOSE
//  Shares one LFSR random engine among NUM_REQ requesters.
//  - Configures the engine's tap and seed, then starts it.
//  - Grants requesters round-robin.
//  - Collects WORD_BITS serial engine bits into one word per grant.
//  - Returns each word over a val/rdy response interface.
//  Sits between the random engine and its client blocks; the engine's own ports connect only here.
// PARAMETERS
//  NUM_REQ    4  number of requesters (legal 2..8)
//  WORD_BITS  8  bits per returned word (legal 2..32)
// PORTS
//  clk          in   1          clock, the codebase's single clock
//  rst          in   1          asynchronous, active-high reset
//  cfg_val      in   1          new tap/seed offered
//  cfg_rdy      out  1          config accepted when cfg_val & cfg_rdy
//  cfg_tap      in   8          LFSR tap mask
//  cfg_seed     in   8          LFSR seed
//  req_val      in   NUM_REQ    per-requester word request
//  req_rdy      out  NUM_REQ    one-hot grant; request accepted on val&rdy
//  resp_val     out  NUM_REQ    one-hot, word valid for granted requester
//  resp_rdy     in   NUM_REQ    per-requester response ready
//  resp_data    out  WORD_BITS  assembled random word, shared bus
//  eng_start    out  1          engine start pulse
//  eng_stop     out  1          engine stop pulse
//  eng_tap      out  8          registered tap to engine
//  eng_seed     out  8          registered seed to engine
//  eng_active   in   1          engine running
//  eng_out      in   1          engine serial bit, fresh each active cycle
//  busy         out  1          high in every state except OFF and IDLE
// BEHAVIOUR
//  Reset, async, rst=1: state=OFF; tap/seed/word/count=0; rr_ptr=0.
//   All outputs 0, except cfg_rdy=1, which is combinational from OFF.
//  Engine contract:
//   - eng_start held 1 for one cycle while the engine is inactive loads seed and runs it.
//   - eng_stop forces the engine idle the next cycle.
//  States and transitions:
//   OFF:    cfg_rdy=1. On cfg fire, latch tap/seed -> STOP.
//   STOP:   eng_stop=1 for one cycle -> LAUNCH.
//   LAUNCH: eng_start=1 for one cycle -> SPINUP.
//   SPINUP: wait for eng_active=1 -> IDLE.
//   IDLE:   cfg_rdy=1.
//           - cfg_val has priority over requests: cfg fire -> STOP; no grant that cycle.
//           - Otherwise req_rdy[g]=1 for the first req_val set, searching from rr_ptr upward with wrap.
//           - On fire: gnt<=g, rr_ptr<=(g+1)%NUM_REQ, count<=0 -> COLLECT.
//   COLLECT: per cycle with eng_active=1, word<={word[WORD_BITS-2:0],eng_out} and count++.
//           - First collected bit ends in the MSB.
//           - After WORD_BITS bits -> RESP.
//           - If eng_active=0, hold word and count; no bit consumed.
//   RESP:   resp_val[gnt]=1, resp_data=word. On resp_rdy[gnt] -> IDLE.
//           - word is held stable until the handshake completes.
//  Handshake rules:
//   - req_rdy and cfg_rdy are never both asserted into a firing pair in the same cycle.
//   - At most one req_rdy bit and one resp_val bit are high.
//   - A requester may keep req_val high for back-to-back words; it is granted again only after round-robin passes.
//  Latency: request fires at cycle t -> resp_val at t+WORD_BITS+1, provided eng_active stays high.
//  Boundaries:
//   - cfg_val outside OFF/IDLE is stalled; cfg_rdy=0.
//   - resp_rdy of non-granted requesters is ignored.
//   - req_val dropped after fire does not cancel the word.
//   - rst mid-COLLECT/RESP: partial word discarded, state=OFF, eng_start/eng_stop=0.
//   - count width is $clog2(WORD_BITS+1); no wrap beyond WORD_BITS.
// TESTING
//  1 Reset then cfg tap=8'hB8 seed=8'h01:
//    -> eng_stop pulse, next cycle eng_start pulse, eng_tap=B8, eng_seed=01, IDLE once eng_active.
//  2 req_val=4'b0001, eng_out stream 1,0,1,1,0,0,1,0:
//    -> resp_val=0001 and resp_data=8'hB2, 9 cycles after fire.
//  3 req_val=4'b1111 held, resp_rdy=all 1:
//    -> grant order 0,1,2,3,0 and exactly one resp_val per word.
//  4 In IDLE, cfg_val and req_val[2] both high:
//    -> cfg fires, req_rdy=0, STOP next.
//  5 resp_rdy low for 5 cycles in RESP:
//    -> resp_data stable and no new grant; eng_active low mid-COLLECT stalls count.
//  6 Assert rst at COLLECT count=4:
//    -> all outputs 0 except cfg_rdy=1; the next request after reconfig yields a full WORD_BITS word.

Source files
------------

// File: rtl/random_word_scheduler.sv
// random_word_scheduler: shares one serial LFSR engine among NUM_REQ clients.
// Programs the engine tap/seed, restarts it, grants requesters round-robin,
// shifts WORD_BITS engine bits into a word and returns it over val/rdy.
module random_word_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_val,
  output logic                 cfg_rdy,
  input  logic [7:0]           cfg_tap,
  input  logic [7:0]           cfg_seed,
  input  logic [NUM_REQ-1:0]   req_val,
  output logic [NUM_REQ-1:0]   req_rdy,
  output logic [NUM_REQ-1:0]   resp_val,
  input  logic [NUM_REQ-1:0]   resp_rdy,
  output logic [WORD_BITS-1:0] resp_data,
  output logic                 eng_start,
  output logic                 eng_stop,
  output logic [7:0]           eng_tap,
  output logic [7:0]           eng_seed,
  input  logic                 eng_active,
  input  logic                 eng_out,
  output logic                 busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_STOP,
    S_LAUNCH,
    S_SPINUP,
    S_IDLE,
    S_COLLECT,
    S_RESP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [NUM_REQ-1:0]   pick_mask;
  logic                 found;
  logic [CNT_W-1:0]     count;
  logic [WORD_BITS-1:0] word;
  logic                 cfg_fire;
  logic                 grant_fire;

  assign resp_data  = word;
  assign cfg_fire   = cfg_val & cfg_rdy;
  // A grant is only offered in IDLE with no pending config, and only to a
  // requester whose req_val is set, so an offered grant always fires.
  assign grant_fire = (state == S_IDLE) && !cfg_val && found;
  assign ptr_nxt    = (32'(pick) == NUM_REQ - 1) ? '0 : pick + PTR_W'(1);

  // Round-robin search: first asserted req_val starting at rr_ptr, with wrap.
  always_comb begin : rr_search
    int unsigned idx;
    idx       = 0;
    found     = 1'b0;
    pick      = '0;
    pick_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_val[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    if (found) pick_mask[pick] = 1'b1;
  end

  // Next-state and handshake/engine-control outputs.
  always_comb begin
    state_nxt = state;
    cfg_rdy   = 1'b0;
    req_rdy   = '0;
    resp_val  = '0;
    eng_start = 1'b0;
    eng_stop  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_OFF: begin
        cfg_rdy = 1'b1;
        busy    = 1'b0;
        if (cfg_val) state_nxt = S_STOP;
      end
      S_STOP: begin
        eng_stop  = 1'b1;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = S_SPINUP;
      end
      S_SPINUP: begin
        if (eng_active) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        cfg_rdy = 1'b1;
        busy    = 1'b0;
        if (cfg_val) begin
          state_nxt = S_STOP;
        end else if (found) begin
          req_rdy   = pick_mask;
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (eng_active && (count == CNT_W'(WORD_BITS - 1))) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_val[gnt] = 1'b1;
        if (resp_rdy[gnt]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OFF;
    else     state <= state_nxt;
  end

  // Engine configuration registers, loaded on every accepted config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_tap  <= '0;
      eng_seed <= '0;
    end else if (cfg_fire) begin
      eng_tap  <= cfg_tap;
      eng_seed <= cfg_seed;
    end
  end

  // Grant bookkeeping and word assembly (first bit ends in the MSB).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      gnt    <= '0;
      count  <= '0;
      word   <= '0;
    end else begin
      if (grant_fire) begin
        gnt    <= pick;
        rr_ptr <= ptr_nxt;
        count  <= '0;
      end
      if ((state == S_COLLECT) && eng_active) begin
        word  <= {word[WORD_BITS-2:0], eng_out};
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_random_word_scheduler.sv
// Scoreboard bench for random_word_scheduler with a behavioural engine model.
module tb_random_word_scheduler;

  localparam int NREQ = 4;
  localparam int WB   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_val = 1'b0;
  logic            cfg_rdy;
  logic [7:0]      cfg_tap = '0;
  logic [7:0]      cfg_seed = '0;
  logic [NREQ-1:0] req_val = '0;
  logic [NREQ-1:0] req_rdy;
  logic [NREQ-1:0] resp_val;
  logic [NREQ-1:0] resp_rdy = '0;
  logic [WB-1:0]   resp_data;
  logic            eng_start;
  logic            eng_stop;
  logic [7:0]      eng_tap;
  logic [7:0]      eng_seed;
  logic            eng_active;
  logic            eng_out = 1'b0;
  logic            busy;

  random_word_scheduler #(.NUM_REQ(NREQ), .WORD_BITS(WB)) dut (
    .clk(clk), .rst(rst),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
    .req_val(req_val), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .eng_start(eng_start), .eng_stop(eng_stop), .eng_tap(eng_tap), .eng_seed(eng_seed),
    .eng_active(eng_active), .eng_out(eng_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: starts on eng_start, idles after eng_stop, fresh bit per cycle.
  logic run = 1'b0;
  logic stall = 1'b0;
  logic manual = 1'b0;
  assign eng_active = run & ~stall;

  initial begin
    logic st, sp;
    forever begin
      @(negedge clk);
      st = eng_start;
      sp = eng_stop;
      @(posedge clk);
      #1;
      if (sp) run = 1'b0;
      else if (st) run = 1'b1;
      if (!manual) eng_out = 1'($urandom);
    end
  end

  // Reference model: round-robin arbitration and word assembly from the engine stream.
  typedef struct {
    int         gnt;
    logic [7:0] word;
    int         arr;
  } exp_t;

  exp_t       sb[$];
  int         m_ptr = 0;
  int         m_gnt = 0;
  int         m_bits = 0;
  bit         m_coll = 0;
  logic [7:0] m_word = '0;
  int         pushed = 0;
  int         resp_count = 0;

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] rv);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ptr + i) % NREQ;
      if (rv[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int   g;
    exp_t e;
    if (rst) begin
      pushed = pushed - sb.size();
      sb.delete();
      m_coll = 0;
      m_ptr  = 0;
    end else begin
      if (m_coll && eng_active) begin
        m_word = {m_word[6:0], eng_out};
        m_bits++;
        if (m_bits == WB) begin
          e.gnt  = m_gnt;
          e.word = m_word;
          e.arr  = cyc + 1;
          sb.push_back(e);
          pushed++;
          m_coll = 0;
        end
      end
      if (cfg_val && cfg_rdy) check("cfg_over_req", 32'(req_rdy), 0);
      g = rr_pick(m_ptr, req_val);
      if (req_rdy != 0) check("grant", 32'(req_rdy), (g < 0) ? 0 : (1 << g));
      if (((req_val & req_rdy) != 0) && (g >= 0)) begin
        m_gnt  = g;
        m_ptr  = (g + 1) % NREQ;
        m_coll = 1;
        m_bits = 0;
        m_word = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  bit              waiting = 0;
  logic [WB-1:0]   held_d;
  logic [NREQ-1:0] held_v;

  always @(negedge clk) begin
    if (rst) begin
      waiting = 0;
    end else if (resp_val != 0) begin
      check("resp_onehot", 32'($onehot(resp_val)), 1);
      check("no_grant_in_resp", 32'(req_rdy), 0);
      if (!waiting) begin
        waiting = 1;
        held_d  = resp_data;
        held_v  = resp_val;
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'(resp_val), 0);
        end else begin
          check("resp_latency", cyc, sb[0].arr);
          check("resp_dest", 32'(resp_val), 1 << sb[0].gnt);
          check("resp_data", 32'(resp_data), 32'(sb[0].word));
        end
      end else begin
        check("resp_hold_data", 32'(resp_data), 32'(held_d));
        check("resp_hold_dest", 32'(resp_val), 32'(held_v));
      end
      if ((resp_val & resp_rdy) != 0) begin
        waiting = 0;
        resp_count++;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic wait_fire(input string nm, output int fc);
    bit ok = 0;
    fc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((req_val & req_rdy) != 0) begin ok = 1; fc = cyc; break; end
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic wait_resp(input string nm, output int rc);
    bit ok = 0;
    rc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_val != 0) begin ok = 1; rc = cyc; break; end
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic do_cfg(input logic [7:0] t, input logic [7:0] s, input bit detail);
    bit ok = 0;
    @(posedge clk); #1;
    cfg_val = 1'b1; cfg_tap = t; cfg_seed = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_rdy) begin ok = 1; break; end
    end
    check("cfg_accept", 32'(ok), 1);
    @(posedge clk); #1;
    cfg_val = 1'b0;
    @(negedge clk);
    if (detail) begin
      check("stop_pulse", 32'(eng_stop), 1);
      check("stop_no_start", 32'(eng_start), 0);
      check("eng_tap", 32'(eng_tap), 32'(t));
      check("eng_seed", 32'(eng_seed), 32'(s));
      check("cfg_rdy_stalled", 32'(cfg_rdy), 0);
    end
    @(negedge clk);
    if (detail) begin
      check("start_pulse", 32'(eng_start), 1);
      check("start_no_stop", 32'(eng_stop), 0);
    end
    wait_idle("spinup_to_idle");
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cfg_rdy"}, 32'(cfg_rdy), 1);
    check({nm, "_req_rdy"}, 32'(req_rdy), 0);
    check({nm, "_resp_val"}, 32'(resp_val), 0);
    check({nm, "_resp_data"}, 32'(resp_data), 0);
    check({nm, "_eng_start"}, 32'(eng_start), 0);
    check({nm, "_eng_stop"}, 32'(eng_stop), 0);
    check({nm, "_eng_tap"}, 32'(eng_tap), 0);
    check({nm, "_eng_seed"}, 32'(eng_seed), 0);
    check({nm, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          fc, rc;
    int          order[$];
    int          exp_order[5];
    logic [7:0]  pat;

    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Configuration and engine bring-up
    do_cfg(8'hB8, 8'h01, 1);
    check("idle_cfg_rdy", 32'(cfg_rdy), 1);

    // Round-robin with every requester held
    @(posedge clk); #1;
    req_val = '1; resp_rdy = '1;
    for (int i = 0; i < 400 && order.size() < 5; i++) begin
      @(negedge clk);
      if ((req_val & req_rdy) != 0) begin
        for (int k = 0; k < NREQ; k++) if (req_rdy[k]) order.push_back(k);
      end
    end
    @(posedge clk); #1;
    req_val = '0;
    check("rr_grants_seen", order.size(), 5);
    for (int i = 0; i < 5; i++) begin
      int got;
      got = (i < order.size()) ? order[i] : -1;
      check($sformatf("rr_order_%0d", i), got, exp_order[i]);
    end
    wait_idle("rr_drain");
    check("rr_one_resp_per_word", resp_count, 5);

    // Config has priority over a pending request
    @(posedge clk); #1;
    cfg_val = 1'b1; cfg_tap = 8'h1D; cfg_seed = 8'h5A; req_val = 4'b0100;
    @(negedge clk);
    check("prio_req_rdy", 32'(req_rdy), 0);
    check("prio_cfg_rdy", 32'(cfg_rdy), 1);
    @(posedge clk); #1;
    cfg_val = 1'b0; req_val = '0;
    @(negedge clk);
    check("prio_stop", 32'(eng_stop), 1);
    check("prio_tap", 32'(eng_tap), 32'h1D);
    wait_idle("prio_reidle");

    // Directed word from a known engine stream
    manual = 1'b1;
    resp_rdy = '0;
    pat = 8'hB2;
    @(posedge clk); #1;
    req_val = 4'b0001;
    wait_fire("word_fire", fc);
    for (int k = 0; k < WB; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_val = '0;
      eng_out = pat[WB-1-k];
    end
    wait_resp("word_resp", rc);
    check("word_latency", rc - fc, WB + 1);
    check("word_dest", 32'(resp_val), 32'b0001);
    check("word_data", 32'(resp_data), 32'hB2);

    // Back-pressure: word held, no new grant
    @(posedge clk); #1;
    req_val = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data", 32'(resp_data), 32'hB2);
      check("bp_dest", 32'(resp_val), 32'b0001);
      check("bp_no_grant", 32'(req_rdy), 0);
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    resp_rdy = '1; manual = 1'b0;

    // Engine stall mid-collect lengthens latency by the stalled cycles
    wait_fire("stall_fire", fc);
    check("stall_grant", 32'(req_rdy), 32'b0010);
    @(posedge clk); #1; req_val = '0;
    @(posedge clk); #1;
    @(posedge clk); #1; stall = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stall = 1'b0;
    wait_resp("stall_resp", rc);
    check("stall_latency", rc - fc, WB + 1 + 3);

    // Reset in the middle of collection
    @(posedge clk); #1;
    req_val = 4'b0001;
    wait_fire("rst_fire", fc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_val = '0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    do_cfg(8'hB8, 8'h01, 0);
    @(posedge clk); #1;
    req_val = 4'b1000;
    wait_fire("after_rst_fire", fc);
    check("after_rst_grant", 32'(req_rdy), 32'b1000);
    @(posedge clk); #1; req_val = '0;
    wait_resp("after_rst_resp", rc);
    check("after_rst_latency", rc - fc, WB + 1);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      req_val  = NREQ'($urandom);
      resp_rdy = NREQ'($urandom);
      stall    = ($urandom_range(0, 4) == 0);
      cfg_val  = ($urandom_range(0, 39) == 0);
      cfg_tap  = 8'($urandom);
      cfg_seed = 8'($urandom);
    end
    @(posedge clk); #1;
    req_val = '0; cfg_val = 1'b0; stall = 1'b0; resp_rdy = '1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_resp_count", resp_count, pushed);
    check("drain_not_collecting", 32'(m_coll), 0);
    check("drain_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
